// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder: one Full_add cell fed LSB-first, one operand bit pair per clock.
// Latency: start accepted at edge E0 -> done pulses in the cycle after edge E0+WIDTH; back-to-back every WIDTH+1 cycles.
// Backpressure: start is sampled only while ready=1; a start seen while busy is ignored.
//
// Ports: clk, rst_n (synchronous, active-low), start, a, b, c_in  -> ready, busy, done, sum, c_out.
// Optional: define SERIAL_ADD_SUB_EN to add input 'sub' (1 = compute a-b, c_out=1 means no borrow).

module Full_add (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] sh_s;

   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] s_next;
   logic [WIDTH-1:0] b_load;
   logic             cin_load;

   // Subtraction is a + ~b + 1; the add-only build has no mux at all.
`ifdef SERIAL_ADD_SUB_EN
   assign b_load   = sub ? ~b : b;
   assign cin_load = sub ? 1'b1 : c_in;
`else
   assign b_load   = b;
   assign cin_load = c_in;
`endif

   Full_add u_fa (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   assign s_next = {fa_s, sh_s[WIDTH-1:1]};

   assign ready = (state != SHIFT);
   assign busy  = (state == SHIFT);
   assign done  = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         carry <= 1'b0;
         sh_a  <= '0;
         sh_b  <= '0;
         sh_s  <= '0;
         sum   <= '0;
         c_out <= 1'b0;
      end else begin
         case (state)
            // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
            IDLE, DONE: begin
               if (start) begin
                  sh_a  <= a;
                  sh_b  <= b_load;
                  carry <= cin_load;
                  cnt   <= '0;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               sh_s  <= s_next;
               carry <= fa_c;
               sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
               sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  sum   <= s_next;
                  c_out <= fa_c;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (WIDTH=8): directed cases plus randomized operations vs. an arithmetic model.
// Latency: each operation is tracked edge by edge from the accepting edge to the done pulse.
// Backpressure: starts raised while busy are injected at random and must be ignored.

module tb_serial_add_seq;

   localparam int W = 8;

`ifdef SERIAL_ADD_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;

   int checks = 0;
   int errors = 0;

   serial_add_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic; subtraction result and no-borrow flag directly.
   function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                        input logic ci, input logic sb);
      logic [W:0] r;
      if (SUB_EN && sb) begin
         r[W-1:0] = av - bv;
         r[W]     = (av >= bv);
      end else begin
         r = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
      end
      return r;
   endfunction

   // Called #1 after an edge with ready=1. Returns #1 after the edge that raises done, start=0.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic sb, input bit noisy, input string tag);
      logic [W:0] exp;
      int bad;
      exp   = model(av, bv, ci, sb);
      start = 1'b1; a = av; b = bv; c_in = ci; sub = sb;
      tick();
      bad = 0;
      for (int i = 0; i < W; i++) begin
         start = noisy ? 1'($urandom) : 1'b0;
         a     = W'($urandom);
         b     = W'($urandom);
         c_in  = 1'($urandom);
         sub   = 1'($urandom);
         if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) bad++;
         tick();
      end
      start = 1'b0;
      chk({tag, "_busy_window"}, 64'(bad), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(1));
      chk({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
      chk({tag, "_cout"}, 64'(c_out), 64'(exp[W]));
   endtask

   initial begin
      int bad;
      logic [W-1:0] ra, rb;
      logic         rc;

      rst_n = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;

      // Random activity, then reset held for two edges.
      for (int i = 0; i < 6; i++) begin
         start = 1'($urandom); a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
         tick();
      end
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_ready", 64'(ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_cout", 64'(c_out), 64'(0));
      start = 1'b0;
      rst_n = 1'b1;
      tick();

      // Basic add and carry boundaries.
      do_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, "basic");
      chk("basic_const", 64'(sum), 64'(8'h8D));
      tick();
      chk("basic_done_one_cycle", 64'(done), 64'(0));
      do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "wrap");
      chk("wrap_const", 64'({c_out, sum}), 64'(9'h100));
      tick();
      do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, "allones");
      chk("allones_const", 64'({c_out, sum}), 64'(9'h1FF));
      tick();

      // Start raised during the operation is ignored; exactly one done pulse.
      start = 1'b1; a = 8'h10; b = 8'h20; c_in = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1; a = 8'h01; b = 8'h01; c_in = 1'b1;
      tick();
      start = 1'b0;
      bad = 0;
      for (int i = 0; i < W + 3; i++) begin
         if (done === 1'b1) bad++;
         tick();
      end
      chk("ignored_start_pulses", 64'(bad), 64'(1));
      chk("ignored_start_sum", 64'({c_out, sum}), 64'(9'h030));

      // Start held in the DONE cycle: next op begins with no IDLE cycle.
      do_op(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, "b2b_first");
      do_op(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, "b2b_second");
      tick();

      // Reset mid-operation aborts; outputs cleared, no done pulse.
      start = 1'b1; a = 8'hAA; b = 8'h55; c_in = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_sum", 64'(sum), 64'(0));
      bad = 0;
      for (int i = 0; i < W + 2; i++) begin
         if (done === 1'b1) bad++;
         tick();
      end
      chk("midrst_no_done", 64'(bad), 64'(0));
      do_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, "after_rst");
      chk("after_rst_const", 64'(sum), 64'(8'h03));
      tick();

`ifdef SERIAL_ADD_SUB_EN
      do_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, "sub_pos");
      chk("sub_pos_const", 64'({c_out, sum}), 64'(9'h10F));
      tick();
      do_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b0, "sub_neg");
      chk("sub_neg_const", 64'({c_out, sum}), 64'(9'h0FF));
      tick();
`endif

      // Randomized operations, noisy inputs while busy, random back-to-back.
      for (int n = 0; n < 30; n++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         do_op(ra, rb, rc, 1'($urandom), 1'b1, "rand");
         if ($urandom_range(0, 1) == 0) tick();
      end
      tick();
      chk("final_hold_ready", 64'(ready), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
